// File: rtl/traffic_light_pkg.sv
// Shared light encodings, tracker state type and error-bit indices for the
// traffic light monitor.
package traffic_light_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    TRK_SYNC   = 2'd0,
    TRK_RED    = 2'd1,
    TRK_GREEN  = 2'd2,
    TRK_YELLOW = 2'd3
  } trk_state_e;

  localparam int ERR_ENC      = 0;
  localparam int ERR_CONFLICT = 1;
  localparam int ERR_SEQ      = 2;
  localparam int ERR_YEL      = 3;
  localparam int ERR_GRN      = 4;
  localparam int NUM_ERR      = 5;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == LIGHT_RED) || (v == LIGHT_YELLOW) || (v == LIGHT_GREEN);
  endfunction

  // Lowest set index wins: ENC is the highest-priority violation.
  function automatic logic [2:0] first_err(input logic [NUM_ERR-1:0] e);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (e[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/light_dir_tracker.sv
// Per-direction phase tracker: decodes one light into RED/GREEN/YELLOW,
// counts dwell and reports sequence, encoding and dwell violations.
module light_dir_tracker
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 8,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  output trk_state_e state,
  output logic       enc_evt,
  output logic       seq_evt,
  output logic       yel_evt,
  output logic       grn_evt,
  output logic       yr_evt
);

  localparam int DW_SAT = GREEN_MAX + 1;
  localparam int DW_W   = $clog2(DW_SAT + 1);

  localparam logic [DW_W-1:0] DW_ONE   = DW_W'(1);
  localparam logic [DW_W-1:0] DW_MAXV  = DW_W'(DW_SAT);
  localparam logic [DW_W-1:0] DW_GMAX  = DW_W'(GREEN_MAX);
  localparam logic [DW_W-1:0] DW_GMIN  = DW_W'(GREEN_MIN);
  localparam logic [DW_W-1:0] DW_YEL   = DW_W'(YELLOW_CYCLES);

  trk_state_e       state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  trk_state_e       obs;
  logic             legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TRK_SYNC;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    obs = TRK_SYNC;
    case (light)
      LIGHT_RED:    obs = TRK_RED;
      LIGHT_GREEN:  obs = TRK_GREEN;
      LIGHT_YELLOW: obs = TRK_YELLOW;
      default:      obs = TRK_SYNC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    enc_evt = 1'b0;
    seq_evt = 1'b0;
    yel_evt = 1'b0;
    grn_evt = 1'b0;
    yr_evt  = 1'b0;
    legal   = ((state_q == TRK_RED)    && (obs == TRK_GREEN))  ||
              ((state_q == TRK_GREEN)  && (obs == TRK_YELLOW)) ||
              ((state_q == TRK_YELLOW) && (obs == TRK_RED));

    if (!is_one_hot(light)) begin
      enc_evt = 1'b1;
      state_d = TRK_SYNC;
      dwell_d = '0;
    end else if (state_q == TRK_SYNC) begin
      if (obs == TRK_RED) begin
        state_d = TRK_RED;
        dwell_d = DW_ONE;
      end
    end else if (obs == state_q) begin
      if (dwell_q != DW_MAXV) dwell_d = dwell_q + DW_ONE;
      // Fires once per green phase: the counter parks at the saturation value.
      if ((state_q == TRK_GREEN) && (dwell_q == DW_GMAX)) grn_evt = 1'b1;
    end else begin
      seq_evt = !legal;
      yel_evt = (state_q == TRK_YELLOW) && (dwell_q != DW_YEL);
      grn_evt = (state_q == TRK_GREEN) && (dwell_q < DW_GMIN);
      yr_evt  = (state_q == TRK_YELLOW) && (obs == TRK_RED);
      state_d = obs;
      dwell_d = DW_ONE;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the NS/EW light outputs: conflict detection, violation
// priority encoding, sticky error registers and NS cycle counting.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light_NS,
  input  logic [2:0]       light_EW,
  input  logic             clr_err,
  output logic             err,
  output logic [4:0]       err_flags,
  output logic [2:0]       err_code,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] cycle_count,
  output trk_state_e       ns_state_dbg,
  output trk_state_e       ew_state_dbg
);

  logic enc_ns, seq_ns, yel_ns, grn_ns, yr_ns;
  logic enc_ew, seq_ew, yel_ew, grn_ew, unused_yr_ew;

  light_dir_tracker #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_ns (
    .clk(clk), .reset(reset), .light(light_NS), .state(ns_state_dbg),
    .enc_evt(enc_ns), .seq_evt(seq_ns), .yel_evt(yel_ns), .grn_evt(grn_ns),
    .yr_evt(yr_ns)
  );

  light_dir_tracker #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_ew (
    .clk(clk), .reset(reset), .light(light_EW), .state(ew_state_dbg),
    .enc_evt(enc_ew), .seq_evt(seq_ew), .yel_evt(yel_ew), .grn_evt(grn_ew),
    .yr_evt(unused_yr_ew)
  );

  logic               err_q, err_d;
  logic [NUM_ERR-1:0] flags_q, flags_d;
  logic [2:0]         code_q, code_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_ERR-1:0] evt;
  logic               conflict;
  logic               err_base;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      flags_q <= '0;
      code_q  <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      err_q   <= err_d;
      flags_q <= flags_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    conflict = is_one_hot(light_NS) && is_one_hot(light_EW) &&
               (light_NS != LIGHT_RED) && (light_EW != LIGHT_RED);

    evt               = '0;
    evt[ERR_ENC]      = enc_ns | enc_ew;
    evt[ERR_CONFLICT] = conflict;
    evt[ERR_SEQ]      = seq_ns | seq_ew;
    evt[ERR_YEL]      = yel_ns | yel_ew;
    evt[ERR_GRN]      = grn_ns | grn_ew;

    // A clear lands first so a same-cycle violation is recorded afresh.
    err_base = clr_err ? 1'b0 : err_q;
    flags_d  = (clr_err ? '0 : flags_q) | evt;
    code_d   = clr_err ? 3'd0 : code_q;
    if ((|evt) && !err_base) code_d = first_err(evt);
    err_d    = err_base | (|evt);
    pulse_d  = |evt;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, yr_ns};
  end

  assign err         = err_q;
  assign err_flags   = flags_q;
  assign err_code    = code_q;
  assign fault_pulse = pulse_q;
  assign cycle_count = count_q;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive protocol checker that sits on the `light_NS`/`light_EW` outputs of the traffic light controller and decodes them back into phases. It tracks each direction's phase sequence and dwell times, and flags encoding, conflict, sequence and timing violations. It also counts completed North-South cycles. It is instantiated beside the controller in system benches and in the FPGA build as a safety watchdog, and never drives the lights.

## Interface
Parameters:
- `GREEN_MIN`, 4: minimum legal green dwell, in clock cycles.
- `GREEN_MAX`, 8: maximum legal green dwell, in clock cycles.
- `YELLOW_CYCLES`, 2: exact legal yellow dwell, in clock cycles.
- `CNT_W`, 16: width of `cycle_count`.

Ports:
- `clk` in 1: single clock; all inputs are sampled on its rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `light_NS` in 3: observed North-South light, one-hot {red, yellow, green}: 100 = red, 010 = yellow, 001 = green.
- `light_EW` in 3: observed East-West light, same encoding.
- `clr_err` in 1: synchronous clear of `err`, `err_flags` and `err_code`.
- `err` out 1: sticky; high once any violation has been seen.
- `err_flags` out 5: sticky OR of violations. Bit 0 ENC, bit 1 CONFLICT, bit 2 SEQ, bit 3 YEL, bit 4 GRN.
- `err_code` out 3: index of the first violation since reset or clear. Holds 0 while `err` is 0.
- `fault_pulse` out 1: one-cycle pulse for each cycle in which at least one new violation is detected.
- `cycle_count` out `CNT_W`: number of completed legal NS yellow→red transitions.

## Operation
- Each direction has one tracker FSM with states SYNC, RED, GREEN, YELLOW, plus a dwell counter that saturates at `GREEN_MAX+1`.
- Tracker leaves SYNC only on a sample of 100, moving to RED. It performs no sequence or dwell checks while in SYNC.
- Legal transitions: RED→GREEN, GREEN→YELLOW, YELLOW→RED. The same value held for consecutive samples is legal.
- Any other change of a valid one-hot value raises SEQ. The tracker then jumps to the state matching the new value, with dwell reset to 1.
- ENC: any sample of either light that is not one-hot. The affected tracker returns to SYNC.
- CONFLICT: a cycle in which neither light is 100, with both samples one-hot.
- YEL: on leaving YELLOW, dwell ≠ `YELLOW_CYCLES`.
- GRN, early case: on leaving GREEN, dwell < `GREEN_MIN`.
- GRN, overrun case: flagged in the cycle where dwell reaches `GREEN_MAX+1` while the light is still green. It is flagged only once per green phase.
- Priority when several violations occur in one cycle: ENC > CONFLICT > SEQ > YEL > GRN. `err_code` takes the highest-priority bit index only if `err` was 0.
- `cycle_count` increments on each legal NS YELLOW→RED and wraps modulo 2^`CNT_W`.
- `clr_err` in the same cycle as a new violation: the violation wins. Flags are cleared, then the new bit is set, `err_code` is loaded with it, and `err` is 1.
- `clr_err` does not affect the trackers or `cycle_count`.

## Timing
- All outputs are registered. A violation in the sample taken at edge N appears on `err`, `err_flags`, `err_code` and `fault_pulse` after edge N, i.e. 1-cycle latency.
- Dwell counts samples: the first sample of a new value gives dwell = 1.
- Reset values: `err`=0, `err_flags`=0, `err_code`=0, `fault_pulse`=0, `cycle_count`=0. Both trackers reset to SYNC with dwell 0.
- Reset assertion mid-phase clears everything immediately, without waiting for a clock edge. After deassertion each tracker resynchronises on its next red sample.
- Combinational path: none from input to output.

## Structure
- Shared package `traffic_light_pkg`:
  - light encodings `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`;
  - tracker state typedef;
  - error bit index constants `ERR_ENC` … `ERR_GRN`.
- Sub-module `light_dir_tracker`, instantiated twice (NS, EW):
  - contains the per-direction FSM and dwell counter;
  - reports decoded state, the ENC/SEQ/YEL/GRN event pulses, and the legal YELLOW→RED pulse.
- Top level holds the CONFLICT check, priority encoding, sticky registers and `cycle_count`.

## Test plan
- Legal run (defaults): NS 100→001×6→010×2→100, EW mirrored, 3 full NS cycles → `err`=0, `cycle_count`=3.
- Conflict: both lights driven 001 for one cycle → `fault_pulse` for 1 cycle, `err_flags`=00010, `err_code`=1.
- Bad encoding: NS=011 → `err_code`=0, NS tracker back in SYNC. A subsequent legal sequence produces no SEQ error until after NS has shown 100.
- Timing: NS green held 3 cycles → GRN on exit. Then after clear, green held 9 cycles → GRN flagged in the 9th sample's following cycle, `err_code`=4. Then yellow held 3 cycles → YEL, bit 3 set.
- Sequence plus clear: NS GREEN→RED directly → `err_code`=2. Then `clr_err`=1 in the same cycle as an EW conflict → `err_flags`=00010, `err_code`=1, `err`=1.
- Reset mid-operation: pull `reset` low between clock edges during NS yellow → all outputs 0 immediately. After release, no SEQ or YEL error is raised for the partial phase.
